// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the memory arbiter
//
// Purpose:
//    Holds the arbiter FSM state encoding, the port selector encoding, the
//    default parameter values and a counter-width helper used by the
//    arbiter and its grant picker.
//
// Contents:
//    arb_state_t   IDLE / ISSUE / WAIT / RESP
//    arb_port_t    PORT_I (fetch) / PORT_D (load/store)
//    DEF_*         default widths, memory latency, starvation limit
//    cnt_bits()    bits needed to hold the values 0..max_val (minimum 1)

package mem_arb_pkg;

   localparam int DEF_ADDR_W     = 32;
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_MEM_LAT    = 1;
   localparam int DEF_STARVE_MAX = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   typedef enum logic {
      PORT_I = 1'b0,
      PORT_D = 1'b1
   } arb_port_t;

   // A counter that only ever holds 0 still needs one flop to exist.
   function automatic int cnt_bits(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - fetch/data priority select with starvation counter
//
// Purpose:
//    Decides which requester wins when the arbiter is free to grant. Data
//    normally has priority; after STARVE_MAX consecutive data grants made
//    while a fetch was waiting, the fetch is forced through.
//
// Ports:
//    clk          in   system clock, rising edge
//    reset        in   asynchronous active-low reset
//    i_req        in   fetch request pending
//    d_req        in   data request pending
//    grant_en     in   arbiter is in a cycle where a grant may be made
//    grant_valid  out  a grant is made this cycle
//    grant_port   out  winning port (meaningful when grant_valid)

module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      i_req,
   input  logic      d_req,
   input  logic      grant_en,
   output logic      grant_valid,
   output arb_port_t grant_port
);

   localparam int CNT_W = cnt_bits(STARVE_MAX);

   logic [CNT_W-1:0] starve_cnt;
   logic             force_fetch;

   assign force_fetch = (starve_cnt == CNT_W'(STARVE_MAX));

   always_comb begin
      grant_valid = grant_en & (i_req | d_req);
      grant_port  = PORT_D;
      if (i_req && (!d_req || force_fetch)) begin
         grant_port = PORT_I;
      end
   end

   // Only data grants that actually overtook a waiting fetch count toward
   // starvation; a fetch grant of any kind restarts the count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt <= '0;
      end else if (grant_valid) begin
         if (grant_port == PORT_I) begin
            starve_cnt <= '0;
         end else if (i_req && !force_fetch) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter/sequencer for the unified memory
//
// Purpose:
//    Serialises CPU fetch reads and load/store accesses onto the single
//    memory port. One transaction at a time: IDLE arbitrates and latches
//    the request, ISSUE drives the strobe for one cycle, WAIT covers the
//    memory read latency, RESP pulses the winning port's ack.
//
// Ports:
//    clk, reset              clock (rising edge), async active-low reset
//    i_req/i_addr            fetch request and address (held until i_ack)
//    i_ack/i_rdata           fetch completion pulse and instruction
//    d_req/d_we/d_addr/d_wdata  data request (held until d_ack)
//    d_ack/d_rdata           data completion pulse and load data
//    mem_read/mem_write      memory strobes (only ever high in ISSUE)
//    mem_addr/mem_wdata      latched address and write data
//    mem_rdata               memory read data, valid MEM_LAT cycles after issue
//    busy                    high whenever a transaction is in flight

module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int MEM_LAT    = DEF_MEM_LAT,
   parameter int STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int              LAT_W    = cnt_bits(MEM_LAT - 1);
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);

   arb_state_t        state;
   arb_state_t        state_n;
   arb_port_t         sel;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] i_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;
   logic [LAT_W-1:0]  lat_cnt;

   logic              grant_en;
   logic              grant_valid;
   arb_port_t         grant_port;
   logic              capture;

   mem_arb_pick #(
      .STARVE_MAX (STARVE_MAX)
   ) u_pick (
      .clk         (clk),
      .reset       (reset),
      .i_req       (i_req),
      .d_req       (d_req),
      .grant_en    (grant_en),
      .grant_valid (grant_valid),
      .grant_port  (grant_port)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Strobes and acks are decoded from state alone so that an asynchronous
   // reset drops them in the same instant the state register clears.
   always_comb begin
      state_n   = state;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      i_ack     = 1'b0;
      d_ack     = 1'b0;
      busy      = 1'b1;
      grant_en  = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            busy     = 1'b0;
            grant_en = 1'b1;
            if (grant_valid) begin
               state_n = ISSUE;
            end
         end
         ISSUE: begin
            mem_write = we_q;
            mem_read  = ~we_q;
            state_n   = we_q ? RESP : WAIT;
         end
         WAIT: begin
            if (lat_cnt == '0) begin
               capture = 1'b1;
               state_n = RESP;
            end
         end
         RESP: begin
            i_ack   = (sel == PORT_I);
            d_ack   = (sel == PORT_D);
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Request latch, latency counter and per-port read data. mem_wdata only
   // moves on a data grant so a fetch leaves the last store value in place.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sel       <= PORT_I;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         lat_cnt   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         if (grant_valid) begin
            sel <= grant_port;
            if (grant_port == PORT_I) begin
               addr_q <= i_addr;
               we_q   <= 1'b0;
            end else begin
               addr_q  <= d_addr;
               we_q    <= d_we;
               wdata_q <= d_wdata;
            end
         end

         if (state == ISSUE && !we_q) begin
            lat_cnt <= LAT_INIT;
         end else if (state == WAIT && lat_cnt != '0) begin
            lat_cnt <= lat_cnt - LAT_W'(1);
         end

         if (capture) begin
            if (sel == PORT_I) begin
               i_rdata_q <= mem_rdata;
            end else begin
               d_rdata_q <= mem_rdata;
            end
         end
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter (MEM_LAT 1 and 3)

module tb_mem_arbiter;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // DUT A: MEM_LAT = 1
   logic        a_i_req, a_i_ack, a_d_req, a_d_we, a_d_ack;
   logic        a_mem_read, a_mem_write, a_busy;
   logic [31:0] a_i_addr, a_i_rdata, a_d_addr, a_d_wdata, a_d_rdata;
   logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

   // DUT B: MEM_LAT = 3
   logic        b_i_req, b_i_ack, b_d_req, b_d_we, b_d_ack;
   logic        b_mem_read, b_mem_write, b_busy;
   logic [31:0] b_i_addr, b_i_rdata, b_d_addr, b_d_wdata, b_d_rdata;
   logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
   logic [31:0] b_p1, b_p2;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut_a (
      .clk(clk), .reset(reset),
      .i_req(a_i_req), .i_addr(a_i_addr), .i_ack(a_i_ack), .i_rdata(a_i_rdata),
      .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
      .d_ack(a_d_ack), .d_rdata(a_d_rdata),
      .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_addr(a_mem_addr),
      .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
   );

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) dut_b (
      .clk(clk), .reset(reset),
      .i_req(b_i_req), .i_addr(b_i_addr), .i_ack(b_i_ack), .i_rdata(b_i_rdata),
      .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
      .d_ack(b_d_ack), .d_rdata(b_d_rdata),
      .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
   );

   // Memory model: data appears exactly MEM_LAT cycles after the read strobe,
   // zero otherwise, so a mistimed capture picks up the wrong value.
   logic [31:0] mem [logic [31:0]];

   function automatic logic [31:0] rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return 32'h0BAD_0000 ^ a;
   endfunction

   always @(posedge clk) begin
      if (a_mem_write) mem[a_mem_addr] = a_mem_wdata;
      a_mem_rdata <= a_mem_read ? rd(a_mem_addr) : 32'h0;
      b_p1        <= b_mem_read ? rd(b_mem_addr) : 32'h0;
      b_p2        <= b_p1;
      b_mem_rdata <= b_p2;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard: expected acks per DUT (port 1 = data, 0 = fetch).
   typedef struct {
      logic        port;
      logic [31:0] data;
      int          at;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];

   always @(negedge clk) begin : mon_a
      exp_t e;
      if (reset) begin
         if (a_mem_read || a_mem_write) check("a_strobe_excl", {31'b0, a_mem_read & a_mem_write}, 32'd0);
         if (a_i_ack || a_d_ack) begin
            check("a_ack_excl", {31'b0, a_i_ack & a_d_ack}, 32'd0);
            if (q_a.size() == 0) begin
               check("a_unexpected_ack", {31'b0, a_d_ack}, 32'hFFFF_FFFF);
            end else begin
               e = q_a.pop_front();
               check("a_ack_port", {31'b0, a_d_ack}, {31'b0, e.port});
               check("a_ack_data", e.port ? a_d_rdata : a_i_rdata, e.data);
               check("a_ack_cycle", cyc, e.at);
            end
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (reset && (b_i_ack || b_d_ack)) begin
         if (q_b.size() == 0) begin
            check("b_unexpected_ack", {31'b0, b_d_ack}, 32'hFFFF_FFFF);
         end else begin
            e = q_b.pop_front();
            check("b_ack_port", {31'b0, b_d_ack}, {31'b0, e.port});
            check("b_ack_data", e.port ? b_d_rdata : b_i_rdata, e.data);
            check("b_ack_cycle", cyc, e.at);
         end
      end
   end

   // Single transaction on DUT A; lat is the hand-computed ack cycle offset.
   task automatic run_a(input logic port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_data, input int lat);
      int c0;
      @(negedge clk);
      c0 = cyc;
      if (port) begin
         a_d_req = 1'b1; a_d_we = we; a_d_addr = addr; a_d_wdata = wdata;
      end else begin
         a_i_req = 1'b1; a_i_addr = addr;
      end
      q_a.push_back('{port, exp_data, c0 + lat});
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         check("a_busy", {31'b0, a_busy}, 32'd1);
         check("a_mem_read", {31'b0, a_mem_read}, {31'b0, (k == 1) && !we});
         check("a_mem_write", {31'b0, a_mem_write}, {31'b0, (k == 1) && we});
         if (k == 1) begin
            check("a_mem_addr", a_mem_addr, addr);
            if (we) check("a_mem_wdata", a_mem_wdata, wdata);
         end
      end
      a_i_req = 1'b0;
      a_d_req = 1'b0;
      @(negedge clk);
      check("a_idle_busy", {31'b0, a_busy}, 32'd0);
   endtask

   initial begin : main
      int c0;
      a_i_req = 0; a_i_addr = 0; a_d_req = 0; a_d_we = 0; a_d_addr = 0; a_d_wdata = 0;
      b_i_req = 0; b_i_addr = 0; b_d_req = 0; b_d_we = 0; b_d_addr = 0; b_d_wdata = 0;
      mem[32'h10] = 32'hDEAD_BEEF;
      mem[32'h20] = 32'h2020_2002;
      mem[32'h30] = 32'h3030_0003;
      mem[32'h08] = 32'hA5A5_A5A5;
      reset = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_busy", {31'b0, a_busy}, 32'd0);
      check("rst_mem_read", {31'b0, a_mem_read}, 32'd0);
      check("rst_mem_write", {31'b0, a_mem_write}, 32'd0);
      check("rst_i_ack", {31'b0, a_i_ack}, 32'd0);
      check("rst_d_ack", {31'b0, a_d_ack}, 32'd0);
      check("rst_i_rdata", a_i_rdata, 32'd0);
      check("rst_d_rdata", a_d_rdata, 32'd0);
      check("rst_mem_addr", a_mem_addr, 32'd0);
      check("rst_mem_wdata", a_mem_wdata, 32'd0);
      check("rst_b_busy", {31'b0, b_busy}, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // Fetch read: ack at cycle 3 with the instruction.
      run_a(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 3);
      // Data write: ack at cycle 2, d_rdata stays at its reset value.
      run_a(1'b1, 1'b1, 32'h40, 32'h1234, 32'h0, 2);
      // Read back the written word.
      run_a(1'b1, 1'b0, 32'h40, 32'h0, 32'h1234, 3);

      // Simultaneous requests: data first (cycle 3), fetch acks at cycle 7.
      @(negedge clk);
      c0 = cyc;
      a_i_req = 1'b1; a_i_addr = 32'h10;
      a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h20;
      q_a.push_back('{1'b1, 32'h2020_2002, c0 + 3});
      q_a.push_back('{1'b0, 32'hDEAD_BEEF, c0 + 7});
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 1) check("sim_first_addr", a_mem_addr, 32'h20);
         if (k == 4) check("sim_gap_idle", {31'b0, a_busy}, 32'd0);
         if (k == 5) begin
            check("sim_fetch_read", {31'b0, a_mem_read}, 32'd1);
            check("sim_fetch_addr", a_mem_addr, 32'h10);
         end
         if (k == 3) a_d_req = 1'b0;
      end
      a_i_req = 1'b0;
      repeat (2) @(negedge clk);

      // Starvation: both held. Four data reads, fetch, four data reads, fetch.
      @(negedge clk);
      c0 = cyc;
      a_i_req = 1'b1; a_i_addr = 32'h30;
      a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h20;
      for (int g = 0; g < 2; g++) begin
         for (int j = 0; j < 4; j++) q_a.push_back('{1'b1, 32'h2020_2002, c0 + 20 * g + 4 * j + 3});
         q_a.push_back('{1'b0, 32'h3030_0003, c0 + 20 * g + 19});
      end
      for (int k = 1; k <= 39; k++) begin
         @(negedge clk);
         if (k == 16) check("starve_cnt_max", 32'(dut_a.u_pick.starve_cnt), 32'd4);
         if (k == 17) check("starve_cnt_clr", 32'(dut_a.u_pick.starve_cnt), 32'd0);
         if (k == 21) check("starve_cnt_one", 32'(dut_a.u_pick.starve_cnt), 32'd1);
      end
      a_i_req = 1'b0;
      a_d_req = 1'b0;
      repeat (2) @(negedge clk);

      // MEM_LAT = 3 data read on DUT B: ack at cycle 5.
      @(negedge clk);
      c0 = cyc;
      b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h08;
      q_b.push_back('{1'b1, 32'hA5A5_A5A5, c0 + 5});
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check("b_busy", {31'b0, b_busy}, 32'd1);
         check("b_mem_read", {31'b0, b_mem_read}, {31'b0, k == 1});
      end
      b_d_req = 1'b0;
      repeat (2) @(negedge clk);

      // Reset during the WAIT cycle of a fetch: outputs clear without a clock.
      @(negedge clk);
      a_i_req = 1'b1; a_i_addr = 32'h10;
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("rstw_busy", {31'b0, a_busy}, 32'd0);
      check("rstw_mem_read", {31'b0, a_mem_read}, 32'd0);
      check("rstw_i_ack", {31'b0, a_i_ack}, 32'd0);
      check("rstw_i_rdata", a_i_rdata, 32'd0);
      a_i_req = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      check("rstw_idle_after", {31'b0, a_busy}, 32'd0);
      run_a(1'b1, 1'b0, 32'h40, 32'h0, 32'h1234, 3);

      repeat (3) @(negedge clk);
      check("sb_a_drained", q_a.size(), 32'd0);
      check("sb_b_drained", q_b.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: time limit reached, got no finish, expected finish");
      $fatal(1);
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer for the single-port unified instruction/data memory.
- Accepts read requests from the CPU fetch port (i_*) and read/write requests from the CPU load/store port (d_*).
- Issues one memory transaction at a time on the memory's mem_read/mem_write/addr/write_data interface and returns read data with a one-cycle ack.
- Sits between the cpu and memory instances inside top. It replaces the direct instruction-register feed from memory output.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles from the mem_read issue cycle until read_data is valid (≥1).
- STARVE_MAX, 4, consecutive data grants allowed while a fetch is pending before the fetch is forced (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- i_req  in  1  fetch request, held until i_ack.
- i_addr  in  ADDR_W  fetch address, stable while i_req is high.
- i_ack  out  1  one-cycle pulse; i_rdata is valid this cycle.
- i_rdata  out  DATA_W  fetched instruction, held until the next fetch ack.
- d_req  in  1  data request, held until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_ack  out  1  one-cycle completion pulse.
- d_rdata  out  DATA_W  load data, updated only on a read ack.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All acks, strobes and busy = 0.
  - i_rdata, d_rdata, mem_addr, mem_wdata = 0.
  - starve_cnt=0, lat_cnt=0.
  - An in-flight transaction is abandoned; its strobes drop immediately and no ack is ever issued for it.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: arbitrate on any request.
  - Only one port requesting: that port wins.
  - Both requesting: data wins unless starve_cnt==STARVE_MAX, in which case fetch wins.
  - Latch winner (sel), address, we and wdata into registers. Next state: ISSUE.
- ISSUE: exactly one cycle.
  - mem_read=1 (fetch, or data with we=0), or mem_write=1 (data with we=1).
  - mem_addr and mem_wdata come from the latched registers.
  - Write: next state RESP. Read: next state WAIT, lat_cnt=MEM_LAT-1.
- WAIT:
  - lat_cnt≠0: decrement.
  - lat_cnt==0: capture mem_rdata into the selected port's rdata register and go to RESP.
- RESP: one cycle. Pulse the selected port's ack, then return to IDLE.
- Latency, with the request sampled in IDLE at cycle 0:
  - Read ack at cycle 2+MEM_LAT.
  - Write ack at cycle 2.
- Strobes are low in every state except ISSUE. Both strobes are never high together.
- Requests are resampled in the IDLE cycle after RESP. A requester that keeps req high there issues a new transaction.
- Requests that drop before ack are undefined: the transaction still completes and the ack still pulses.
- starve_cnt (0..STARVE_MAX):
  - Increments, saturating, on each data grant made while i_req=1.
  - Clears on every fetch grant.
  - Unaffected when fetch is idle.
- Non-selected port outputs hold their values. rdata of a port changes only in its own WAIT capture cycle.

Decomposition:
- mem_arb_pkg holds:
  - state enum arb_state_t {IDLE, ISSUE, WAIT, RESP}.
  - port enum arb_port_t {PORT_I, PORT_D}.
  - Default width constants.
- One sub-module, mem_arb_pick: combinational priority select plus the starve_cnt register.
  - Inputs: i_req, d_req, grant_en.
  - Outputs: grant_valid, grant_port.
- The FSM, latency counter and data registers stay in mem_arbiter.

Test Plan:
- Fetch read, MEM_LAT=1:
  - Stimulus: i_req=1, i_addr=0x10, memory returns 0xDEADBEEF.
  - Required: mem_read high only in cycle 1 with mem_addr=0x10; i_ack in cycle 3 with i_rdata=0xDEADBEEF; busy high cycles 1–3.
- Data write:
  - Stimulus: d_req=1, d_we=1, d_addr=0x40, d_wdata=0x1234.
  - Required: mem_write high only in cycle 1 with mem_wdata=0x1234; d_ack in cycle 2; d_rdata unchanged; mem_read never high.
- Simultaneous requests:
  - Stimulus: i_req and d_req both high in cycle 0, starve_cnt=0.
  - Required: data served first (d_ack cycle 3); fetch issued in the following IDLE+1 cycle; i_ack at cycle 7.
- Starvation, STARVE_MAX=4:
  - Stimulus: d_req held high continuously with reads; i_req held high.
  - Required: exactly 4 d_acks, then the fetch is granted; starve_cnt returns to 0; the next data grant increments it to 1.
- MEM_LAT=3 read:
  - Stimulus: d_req read at 0x8, memory returns 0xA5A5A5A5.
  - Required: d_ack in cycle 5 with d_rdata=0xA5A5A5A5; mem_read high only in cycle 1.
- Reset mid-WAIT:
  - Stimulus: reset=0 during WAIT of a fetch.
  - Required: busy, mem_read and i_ack are 0 immediately without waiting for clk; i_rdata=0; state IDLE; no ack follows after reset releases; a new request then completes normally.
